qos_traffic_gen: RTL



---
 rtl/qos_traffic_gen.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/qos_traffic_gen.sv
`timescale 1ns/1ps
// qos_traffic_gen: LFSR traffic source into the Main FIFO plus round-robin drain of the
// destination FIFOs, with per-channel counting and stall detection. QOS_TG_CHECK_EN adds checksums.
module qos_traffic_gen #(
    parameter int unsigned    BW       = 6,
    parameter int unsigned    NCH      = 2,
    parameter int unsigned    CW       = $clog2(NCH),
    parameter int unsigned    CNT_W    = 8,
    parameter logic [BW-1:0]  SEED     = 6'b10_0001,
    parameter logic [BW-1:0]  POLY     = 6'b11_0000,
    parameter int unsigned    WAIT_CYC = 10,
    parameter int unsigned    TO_W     = 6
) (
    input  logic                 clk,
    input  logic                 reset_L,
    input  logic                 start,
    input  logic                 mode,
    input  logic [CNT_W-1:0]     n_words,
    input  logic                 main_full,
    output logic                 main_wr,
    output logic [BW-1:0]        main_data,
    input  logic [NCH-1:0]       dst_empty,
    output logic [NCH-1:0]       dst_rd,
    input  logic [NCH*BW-1:0]    dst_data,
    output logic                 busy,
    output logic                 done,
    output logic                 err_timeout,
    output logic                 err_mismatch,
    output logic [NCH*CNT_W-1:0] rx_count
);

    typedef enum logic [2:0] {S_IDLE, S_FILL, S_WAIT, S_DRAIN, S_STREAM, S_DONE} state_t;

    localparam int unsigned   WC_W    = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;
    localparam logic [TO_W-1:0] TO_LAST = {{(TO_W-1){1'b1}}, 1'b0};

    state_t              state, state_nx;
    logic [BW-1:0]       lfsr, lfsr_nx;
    logic [CNT_W-1:0]    n_words_q, tx_cnt, rx_total;
    logic [CNT_W-1:0]    rx_cnt [NCH];
    logic [WC_W-1:0]     wait_cnt;
    logic [TO_W-1:0]     to_cnt;
    logic [CW-1:0]       last, rd_sel, rd_idx, cand;
    logic                rd_vld, rd_any, pop, start_ok;
    logic                tx_on, tx_done, rx_on, rx_last, stall_hit, watch;
    logic [CNT_W:0]      rx_sum;
    logic                err_to_q;
    logic [CW-1:0]       tx_cls;

    assign start_ok    = start && (state == S_IDLE || state == S_DONE);
    assign tx_on       = (state == S_FILL || state == S_STREAM) && (tx_cnt < n_words_q);
    assign main_wr     = tx_on && !main_full;
    assign main_data   = lfsr;
    assign tx_cls      = lfsr[BW-1 -: CW];
    assign lfsr_nx     = (lfsr >> 1) ^ (lfsr[0] ? POLY : '0);
    assign tx_done     = (tx_cnt == n_words_q);
    assign rx_on       = (state == S_DRAIN || state == S_STREAM);
    assign watch       = (state == S_FILL) || rx_on;
    // Completion counts the capture landing on this edge, so done follows it by one cycle.
    assign rx_sum      = {1'b0, rx_total} + {{CNT_W{1'b0}}, rd_vld};
    assign rx_last     = (rx_sum == {1'b0, n_words_q});
    assign stall_hit   = watch && !main_wr && !pop && (to_cnt == TO_LAST);
    assign busy        = !(state == S_IDLE || state == S_DONE);
    assign done        = (state == S_DONE);
    assign err_timeout = err_to_q;

    always_comb begin
        rd_any = 1'b0;
        rd_sel = last;
        cand   = '0;
        for (int unsigned k = 1; k <= NCH; k++) begin
            cand = last + CW'(k);
            if (!rd_any && !dst_empty[cand]) begin
                rd_any = 1'b1;
                rd_sel = cand;
            end
        end
        pop    = rx_on && rd_any;
        dst_rd = '0;
        if (pop) dst_rd[rd_sel] = 1'b1;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    if (n_words == '0) state_nx = S_DONE;
                    else if (mode)     state_nx = S_STREAM;
                    else               state_nx = S_FILL;
                end
            end
            S_FILL: begin
                if (stall_hit)                                       state_nx = S_DONE;
                else if (main_wr && (tx_cnt + CNT_W'(1) == n_words_q)) state_nx = S_WAIT;
            end
            S_WAIT: begin
                if (wait_cnt == WC_W'(WAIT_CYC - 1)) state_nx = S_DRAIN;
            end
            S_DRAIN, S_STREAM: begin
                if (stall_hit || (tx_done && rx_last)) state_nx = S_DONE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) state <= S_IDLE;
        else          state <= state_nx;
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            lfsr      <= SEED;
            n_words_q <= '0;
            tx_cnt    <= '0;
            rx_total  <= '0;
            wait_cnt  <= '0;
            to_cnt    <= '0;
            last      <= '0;
            rd_idx    <= '0;
            rd_vld    <= 1'b0;
            err_to_q  <= 1'b0;
            for (int unsigned i = 0; i < NCH; i++) rx_cnt[i] <= '0;
        end else if (start_ok) begin
            lfsr      <= SEED;
            n_words_q <= n_words;
            tx_cnt    <= '0;
            rx_total  <= '0;
            wait_cnt  <= '0;
            to_cnt    <= '0;
            last      <= '0;
            rd_idx    <= '0;
            rd_vld    <= 1'b0;
            err_to_q  <= 1'b0;
            for (int unsigned i = 0; i < NCH; i++) rx_cnt[i] <= '0;
        end else begin
            if (main_wr) begin
                lfsr   <= lfsr_nx;
                tx_cnt <= tx_cnt + CNT_W'(1);
            end
            if (pop) last <= rd_sel;
            rd_vld <= pop;
            rd_idx <= rd_sel;
            if (rd_vld) begin
                rx_cnt[rd_idx] <= rx_cnt[rd_idx] + CNT_W'(1);
                rx_total       <= rx_total + CNT_W'(1);
            end
            if (main_wr || pop) to_cnt <= '0;
            else if (watch)     to_cnt <= to_cnt + TO_W'(1);
            if (stall_hit) err_to_q <= 1'b1;
            if (state == S_WAIT) wait_cnt <= wait_cnt + WC_W'(1);
            else                 wait_cnt <= '0;
        end
    end

    always_comb begin
        rx_count = '0;
        for (int unsigned i = 0; i < NCH; i++) rx_count[i*CNT_W +: CNT_W] = rx_cnt[i];
    end

`ifdef QOS_TG_CHECK_EN
    logic [CNT_W-1:0] tx_cnt_c [NCH];
    logic [BW-1:0]    tx_xor   [NCH];
    logic [BW-1:0]    rx_xor   [NCH];
    logic [BW-1:0]    rx_word;
    logic [CNT_W-1:0] cnt_nx;
    logic [BW-1:0]    xor_nx;
    logic             hit, mis_nx, err_mis_q;

    assign rx_word      = dst_data[rd_idx*BW +: BW];
    assign err_mismatch = err_mis_q;

    // Compare against post-capture values so the final word is included at DONE entry.
    always_comb begin
        mis_nx = 1'b0;
        hit    = 1'b0;
        cnt_nx = '0;
        xor_nx = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            hit    = rd_vld && (rd_idx == CW'(i));
            cnt_nx = rx_cnt[i] + {{(CNT_W-1){1'b0}}, hit};
            xor_nx = rx_xor[i] ^ (hit ? rx_word : '0);
            if (cnt_nx != tx_cnt_c[i] || xor_nx != tx_xor[i]) mis_nx = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            err_mis_q <= 1'b0;
            for (int unsigned i = 0; i < NCH; i++) begin
                tx_cnt_c[i] <= '0;
                tx_xor[i]   <= '0;
                rx_xor[i]   <= '0;
            end
        end else if (start_ok) begin
            err_mis_q <= 1'b0;
            for (int unsigned i = 0; i < NCH; i++) begin
                tx_cnt_c[i] <= '0;
                tx_xor[i]   <= '0;
                rx_xor[i]   <= '0;
            end
        end else begin
            if (main_wr) begin
                tx_cnt_c[tx_cls] <= tx_cnt_c[tx_cls] + CNT_W'(1);
                tx_xor[tx_cls]   <= tx_xor[tx_cls] ^ lfsr;
            end
            if (rd_vld) rx_xor[rd_idx] <= rx_xor[rd_idx] ^ rx_word;
            if (state_nx == S_DONE && state != S_DONE) err_mis_q <= mis_nx;
        end
    end
`else
    logic unused_data;
    assign unused_data  = ^{dst_data, tx_cls};
    assign err_mismatch = 1'b0;
`endif

endmodule
